// File: rtl/krv_flash_arb_if.sv
// Bus bundle between the flash arbiter, its two requesters (IF, DM) and the
// flash subsystem read port. The slave modport is the arbiter's view.
interface krv_flash_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_err;
  logic          dm_req;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          dm_err;
  logic          fl_req;
  logic [AW-1:0] fl_addr;
  logic [DW-1:0] fl_rdata;
  logic          fl_ack;
  logic          busy;
  logic          owner;

  modport slave (
    input  if_req, if_addr, dm_req, dm_addr, fl_rdata, fl_ack,
    output if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
           fl_req, fl_addr, busy, owner
  );

  modport master (
    output if_req, if_addr, dm_req, dm_addr, fl_rdata, fl_ack,
    input  if_rdata, if_ack, if_err, dm_rdata, dm_ack, dm_err,
           fl_req, fl_addr, busy, owner
  );
endinterface

// File: rtl/krv_flash_arb.sv
// Flash read-port arbiter: serialises IF and DM reads onto one flash port.
// DM has priority, but IF never waits behind more than STARVE_MAX DM grants.
// Flash reads that do not complete within TIMEOUT cycles are aborted with err.
module krv_flash_arb #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input logic               cpu_clk,
  input logic               rst,
  krv_flash_arb_if.slave    bus
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);
  localparam logic [7:0] LP_TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t        r_state;
  logic [3:0]    r_starve;
  logic [7:0]    r_tmo;
  logic          r_owner;
  logic          r_fl_req;
  logic [AW-1:0] r_fl_addr;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;
  logic          r_if_ack;
  logic          r_if_err;
  logic          r_dm_ack;
  logic          r_dm_err;
  logic          r_busy;
  logic          w_dm_win;

  // DM wins unless IF is waiting and has already been passed over STARVE_MAX times
  assign w_dm_win = bus.dm_req && (!bus.if_req || (r_starve < LP_STARVE_MAX));

  // Single FSM: arbitration in IDLE, flash access + timeout in BUSY, one-cycle response in RESP
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_starve   <= 4'd0;
      r_tmo      <= 8'd0;
      r_owner    <= 1'b0;
      r_fl_req   <= 1'b0;
      r_fl_addr  <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_ack   <= 1'b0;
      r_if_err   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_dm_err   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.if_req || bus.dm_req) begin
            r_state   <= S_BUSY;
            r_fl_req  <= 1'b1;
            r_busy    <= 1'b1;
            r_tmo     <= 8'd0;
            r_owner   <= w_dm_win;
            r_fl_addr <= w_dm_win ? bus.dm_addr : bus.if_addr;
            if (!w_dm_win) begin
              r_starve <= 4'd0;
            end else if (bus.if_req && (r_starve < LP_STARVE_MAX)) begin
              r_starve <= r_starve + 4'd1;
            end
          end
        end
        S_BUSY: begin
          // A completion on the final timeout cycle still counts as success
          if (bus.fl_ack) begin
            r_state  <= S_RESP;
            r_fl_req <= 1'b0;
            if (r_owner) begin
              r_dm_rdata <= bus.fl_rdata;
              r_dm_ack   <= 1'b1;
            end else begin
              r_if_rdata <= bus.fl_rdata;
              r_if_ack   <= 1'b1;
            end
          end else if (r_tmo == LP_TMO_LAST) begin
            r_state  <= S_RESP;
            r_fl_req <= 1'b0;
            if (r_owner) begin
              r_dm_rdata <= '0;
              r_dm_err   <= 1'b1;
            end else begin
              r_if_rdata <= '0;
              r_if_err   <= 1'b1;
            end
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_if_ack <= 1'b0;
          r_if_err <= 1'b0;
          r_dm_ack <= 1'b0;
          r_dm_err <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fl_req   = r_fl_req;
  assign bus.fl_addr  = r_fl_addr;
  assign bus.if_rdata = r_if_rdata;
  assign bus.if_ack   = r_if_ack;
  assign bus.if_err   = r_if_err;
  assign bus.dm_rdata = r_dm_rdata;
  assign bus.dm_ack   = r_dm_ack;
  assign bus.dm_err   = r_dm_err;
  assign bus.busy     = r_busy;
  assign bus.owner    = r_owner;

endmodule

// File: tb/tb_krv_flash_arb.sv
// Scoreboard bench for krv_flash_arb: directed requests push expected responses,
// a monitor pops and compares on every ack/err pulse; a flash model answers reads.
module tb_krv_flash_arb;

  logic cpu_clk = 1'b0;
  logic rst     = 1'b1;

  krv_flash_arb_if #(.AW(16), .DW(32)) bus ();

  krv_flash_arb #(.AW(16), .DW(32), .STARVE_MAX(4), .TIMEOUT(64)) u_dut (
    .cpu_clk (cpu_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic        owner;
    logic        err;
    logic [31:0] data;
    logic [15:0] addr;
  } exp_t;

  exp_t        sbq[$];
  int          ack_cyc[$];
  int          n_vec  = 0;
  int          n_mis  = 0;
  int          n_done = 0;
  int          cyc    = 0;

  // flash model controls
  int          fl_lat      = 1;
  int          fl_cnt      = 0;
  logic        fl_manual   = 1'b0;
  logic        fl_fixed_en = 1'b0;
  logic [31:0] fl_fixed    = 32'h0;
  logic [15:0] seen_addr   = 16'h0;

  function automatic logic [31:0] fdata(logic [15:0] a);
    return {~a, a};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic o, logic e, logic [31:0] d, logic [15:0] a);
    exp_t x;
    x.owner = o; x.err = e; x.data = d; x.addr = a;
    return x;
  endfunction

  task automatic wait_done(int target, int budget, string name);
    for (int i = 0; i < budget && n_done < target; i++) begin
      @(negedge cpu_clk); #1;
    end
    if (n_done < target) chk(name, n_done, target);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_fl_req"},   {31'd0, bus.fl_req}, 32'd0);
    chk({tag, "_busy"},     {31'd0, bus.busy},   32'd0);
    chk({tag, "_owner"},    {31'd0, bus.owner},  32'd0);
    chk({tag, "_acks"},     {28'd0, bus.if_ack, bus.if_err, bus.dm_ack, bus.dm_err}, 32'd0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, bus.dm_rdata, 32'd0);
    chk({tag, "_fl_addr"},  {16'd0, bus.fl_addr}, 32'd0);
  endtask

  // cycle counter
  initial forever begin
    @(posedge cpu_clk);
    cyc++;
  end

  // flash model: ack fl_lat cycles after fl_req first seen (negative = never)
  initial forever begin
    @(negedge cpu_clk);
    if (!fl_manual) begin
      if (bus.fl_ack) bus.fl_ack = 1'b0;
      if (!bus.fl_req) begin
        fl_cnt = 0;
      end else begin
        if (fl_cnt == 0) seen_addr = bus.fl_addr;
        if (fl_lat >= 0 && fl_cnt == fl_lat) begin
          bus.fl_ack   = 1'b1;
          bus.fl_rdata = fl_fixed_en ? fl_fixed : fdata(bus.fl_addr);
        end
        fl_cnt++;
      end
    end
  end

  // response monitor: pops the scoreboard on every response pulse
  initial forever begin
    @(negedge cpu_clk);
    if (!rst && (bus.if_ack || bus.if_err || bus.dm_ack || bus.dm_err)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", {28'd0, bus.if_ack, bus.if_err, bus.dm_ack, bus.dm_err}, 32'd0);
      end else begin
        exp_t e;
        logic o;
        e = sbq.pop_front();
        o = bus.dm_ack | bus.dm_err;
        chk("resp_owner", {31'd0, o}, {31'd0, e.owner});
        chk("resp_err", {31'd0, o ? bus.dm_err : bus.if_err}, {31'd0, e.err});
        chk("resp_data", o ? bus.dm_rdata : bus.if_rdata, e.data);
        chk("resp_other_quiet", {30'd0, o ? {bus.if_ack, bus.if_err} : {bus.dm_ack, bus.dm_err}}, 32'd0);
        chk("resp_fl_addr", {16'd0, seen_addr}, {16'd0, e.addr});
        chk("resp_owner_out", {31'd0, bus.owner}, {31'd0, e.owner});
      end
      ack_cyc.push_back(cyc);
      n_done++;
    end
  end

  initial begin
    int c0, hi, n0, k0;
    logic [15:0] a6[3];
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_addr = '0;
    bus.fl_ack = 0; bus.fl_rdata = '0;

    // reset state
    repeat (3) @(negedge cpu_clk);
    rst = 1'b0;
    @(negedge cpu_clk); #1;
    chk_all_zero("reset");

    // 1: IF only, L=2, ack in cycle 4
    fl_lat = 2;
    sbq.push_back(mk(1'b0, 1'b0, 32'hDEADBEEF, 16'h0040));
    fl_fixed_en = 1'b1; fl_fixed = 32'hDEADBEEF;
    bus.if_addr = 16'h0040; bus.if_req = 1'b1; c0 = cyc;
    wait_done(1, 50, "t1_timeout");
    bus.if_req = 1'b0; fl_fixed_en = 1'b0;
    chk("t1_latency", ack_cyc[ack_cyc.size()-1] - c0, 32'd4);

    // 2: both held, DM x4 then IF, twice
    @(negedge cpu_clk); #1;
    fl_lat = 1;
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) sbq.push_back(mk(1'b1, 1'b0, fdata(16'h2000), 16'h2000));
      sbq.push_back(mk(1'b0, 1'b0, fdata(16'h1000), 16'h1000));
    end
    n0 = n_done;
    bus.if_addr = 16'h1000; bus.dm_addr = 16'h2000;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    wait_done(n0 + 10, 300, "t2_timeout");
    bus.if_req = 1'b0; bus.dm_req = 1'b0;

    // 3: flash never acks -> DM timeout after 64 fl_req cycles
    @(negedge cpu_clk); #1;
    fl_lat = -1; hi = 0; n0 = n_done;
    sbq.push_back(mk(1'b1, 1'b1, 32'h0, 16'h0300));
    bus.dm_addr = 16'h0300; bus.dm_req = 1'b1;
    for (int i = 0; i < 200 && n_done < n0 + 1; i++) begin
      @(negedge cpu_clk); #1;
      if (bus.fl_req) hi++;
    end
    bus.dm_req = 1'b0;
    chk("t3_done", n_done, n0 + 1);
    chk("t3_fl_req_cycles", hi, 32'd64);
    @(negedge cpu_clk); #1;
    chk("t3_busy_after", {31'd0, bus.busy}, 32'd0);
    fl_lat = 2; n0 = n_done;
    sbq.push_back(mk(1'b1, 1'b0, fdata(16'h0304), 16'h0304));
    bus.dm_addr = 16'h0304; bus.dm_req = 1'b1;
    wait_done(n0 + 1, 50, "t3_next_timeout");
    bus.dm_req = 1'b0;

    // 4: fl_ack on the exact timeout cycle completes normally
    @(negedge cpu_clk); #1;
    fl_lat = 63; fl_fixed_en = 1'b1; fl_fixed = 32'h12345678; n0 = n_done;
    sbq.push_back(mk(1'b0, 1'b0, 32'h12345678, 16'h0500));
    bus.if_addr = 16'h0500; bus.if_req = 1'b1;
    wait_done(n0 + 1, 200, "t4_timeout");
    bus.if_req = 1'b0; fl_fixed_en = 1'b0;

    // 5: reset pulse during BUSY, late fl_ack ignored
    @(negedge cpu_clk); #1;
    fl_manual = 1'b1; n0 = n_done;
    bus.if_addr = 16'h0600; bus.if_req = 1'b1;
    for (int i = 0; i < 20 && !bus.fl_req; i++) begin
      @(negedge cpu_clk); #1;
    end
    chk("t5_fl_req_seen", {31'd0, bus.fl_req}, 32'd1);
    @(negedge cpu_clk);
    rst = 1'b1; bus.if_req = 1'b0;
    @(negedge cpu_clk);
    rst = 1'b0; #1;
    chk_all_zero("t5_after_rst");
    @(negedge cpu_clk);
    bus.fl_ack = 1'b1; bus.fl_rdata = 32'hBAD0BAD0;
    @(negedge cpu_clk);
    bus.fl_ack = 1'b0;
    repeat (4) @(negedge cpu_clk);
    #1;
    chk("t5_no_resp", n_done, n0);
    chk("t5_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_idle_fl_req", {31'd0, bus.fl_req}, 32'd0);
    fl_manual = 1'b0; fl_cnt = 0; fl_lat = 1;
    sbq.push_back(mk(1'b0, 1'b0, fdata(16'h0610), 16'h0610));
    bus.if_addr = 16'h0610; bus.if_req = 1'b1;
    wait_done(n0 + 1, 50, "t5_next_timeout");
    bus.if_req = 1'b0;

    // 6: L=0 back-to-back IF with req held, address changes each access
    @(negedge cpu_clk); #1;
    fl_lat = 0; n0 = n_done; k0 = ack_cyc.size();
    a6[0] = 16'h0700; a6[1] = 16'h0704; a6[2] = 16'h0708;
    for (int i = 0; i < 3; i++) sbq.push_back(mk(1'b0, 1'b0, fdata(a6[i]), a6[i]));
    bus.if_addr = a6[0]; bus.if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done(n0 + i + 1, 30, "t6_timeout");
      if (i < 2) bus.if_addr = a6[i+1];
    end
    bus.if_req = 1'b0;
    if (ack_cyc.size() >= k0 + 3) begin
      chk("t6_spacing_1", ack_cyc[k0+1] - ack_cyc[k0], 32'd3);
      chk("t6_spacing_2", ack_cyc[k0+2] - ack_cyc[k0+1], 32'd3);
    end else begin
      chk("t6_ack_count", ack_cyc.size() - k0, 32'd3);
    end

    repeat (5) @(negedge cpu_clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
